// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, one full-adder cell plus a carry
//               flop, LSB first, with start/busy/done handshake.
//               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port (a - b).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
    logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
    // Only WIDTH-1 partial bits need storing; the final bit goes straight to sum.
    logic [WIDTH-2:0] r_work, w_work_nxt;
    logic             r_carry, w_carry_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_cout, w_cout_nxt;

    logic             w_s, w_c;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_cap;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cin is ignored in this mode.
    assign w_b_cap = sub ? ~b : b;
    assign w_c_cap = sub ? 1'b1 : cin;
`else
    assign w_b_cap = b;
    assign w_c_cap = cin;
`endif

    assign w_s     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c     = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_shift = {w_s, r_work};

    always_comb begin
        w_state_nxt = r_state;
        w_a_sh_nxt  = r_a_sh;
        w_b_sh_nxt  = r_b_sh;
        w_work_nxt  = r_work;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start) begin
                    w_a_sh_nxt  = a;
                    w_b_sh_nxt  = w_b_cap;
                    w_carry_nxt = w_c_cap;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_a_sh_nxt  = r_a_sh >> 1;
                w_b_sh_nxt  = r_b_sh >> 1;
                w_work_nxt  = w_shift[WIDTH-1:1];
                w_carry_nxt = w_c;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (r_cnt == c_CNT_LAST) begin
                    w_sum_nxt   = w_shift;
                    w_cout_nxt  = w_c;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a_sh  <= w_a_sh_nxt;
            r_b_sh  <= w_b_sh_nxt;
            r_work  <= w_work_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder (WIDTH=8 and WIDTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    typedef struct {
        logic [8:0] res;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst3, start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8, sub3;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q3[$];
    logic [3:0] last3;
    logic       have_last3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub3),
`endif
        .sum(sum3), .cout(cout3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc, input logic ms);
        if (ms) return {1'b0, ma} + {1'b0, ~mb} + 9'd1;
        return {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
    endfunction

    // Output monitors: pop the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done8) begin
                if (q8.size() == 0) check("done8_unexpected", 32'(done8), 32'd0);
                else begin
                    e = q8.pop_front();
                    check("result8", {23'd0, cout8, sum8}, {23'd0, e.res});
                    check("latency8", cyc, e.due);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done3) begin
                if (q3.size() == 0) check("done3_unexpected", 32'(done3), 32'd0);
                else begin
                    e = q3.pop_front();
                    check("result3", {28'd0, cout3, sum3}, {23'd0, e.res});
                    last3      = {cout3, sum3};
                    have_last3 = 1'b1;
                end
            end else if (have_last3) begin
                check("hold3", {28'd0, cout3, sum3}, {28'd0, last3});
            end
        end
    end

    task automatic wait_done8();
        for (int k = 0; k < 30 && !done8; k++) @(negedge clk);
        check("done8_seen", 32'(done8), 32'd1);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic ts);
        int nb;
        @(negedge clk);
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = ts;
`endif
        q8.push_back('{res: model8(ta, tb_v, tc, ts), due: cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        nb = 0;
        for (int k = 0; k < 30 && !done8; k++) begin
            if (busy8) nb++;
            @(negedge clk);
        end
        check("done8_seen", 32'(done8), 32'd1);
        check("busy8_len", nb, 8);
    endtask

    task automatic op3(input logic [2:0] ta, input logic [2:0] tb_v, input logic tc);
        @(negedge clk);
        a3 = ta; b3 = tb_v; cin3 = tc; start3 = 1'b1;
        q3.push_back('{res: 9'({1'b0, ta} + {1'b0, tb_v} + {3'd0, tc}), due: cyc + 4});
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 20 && !done3; k++) @(negedge clk);
        check("done3_seen", 32'(done3), 32'd1);
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub3 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_sum8",  32'(sum8),  32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        rst8 = 1'b0; rst3 = 1'b0;

        op8(8'h00, 8'h00, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1, 1'b0);
        op8(8'h3C, 8'h42, 1'b0, 1'b0);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{res: model8(8'h12, 8'h34, 1'b0, 1'b0), due: cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        repeat (12) @(negedge clk);

        // start held high through DONE launches a back-to-back operation
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{res: model8(8'h10, 8'h20, 1'b0, 1'b0), due: cyc + 9});
        @(negedge clk);
        wait_done8();
        a8 = 8'h30; b8 = 8'h40; cin8 = 1'b1;
        q8.push_back('{res: model8(8'h30, 8'h40, 1'b1, 1'b0), due: cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy8", 32'(busy8), 32'd1);
        wait_done8();

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy8", 32'(busy8), 32'd1);
        rst8 = 1'b1;
        @(negedge clk);
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_sum8",  32'(sum8),  32'd0);
        check("abort_cout8", 32'(cout8), 32'd0);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_idle8", 32'(busy8), 32'd0);
        op8(8'h3C, 8'h42, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h05, 8'h07, 1'b0, 1'b1);
        op8(8'h07, 8'h05, 1'b0, 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            op3(v[6:4], v[3:1], v[0]);
        end

        repeat (5) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder; successor to the 1-bit dataflow full adder.
- Adds two WIDTH-bit operands plus carry-in using one full-adder cell and a carry flip-flop, one bit per clock, LSB first.
- Uses a start/busy/done handshake and is intended for area-constrained datapaths where latency is acceptable.
- Result registers hold the last completed sum, so consumers never see partial results.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2

Ports:
clk     input   1      single system clock, rising edge
rst     input   1      synchronous reset, active-high
start   input   1      request; sampled only in IDLE or DONE
a       input   WIDTH  operand A; captured on accepted start
b       input   WIDTH  operand B; captured on accepted start
cin     input   1      carry-in; captured on accepted start
sum     output  WIDTH  registered result of last completed operation
cout    output  1      registered carry-out of last completed operation
busy    output  1      high while bits are being processed
done    output  1      one-cycle pulse when sum/cout update

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All state changes on rising edge of clk.
- Reset values:
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Internal shift registers, carry flop and bit counter = 0.
- States:
  - IDLE: busy=0, done=0. start=1 -> capture a, b into operand shift regs; carry flop=cin; counter=0; go to RUN.
  - RUN: busy=1, done=0.
    - Each cycle: s = a_sh[0]^b_sh[0]^c; c_next = majority(a_sh[0], b_sh[0], c).
    - s enters working reg at MSB, working reg shifts right; a_sh and b_sh shift right; counter++.
    - When counter==WIDTH-1 (WIDTH-th bit processed): sum<=final working value, cout<=c_next, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 -> capture and go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Latency: start sampled at edge 0 -> busy high after edges 0..WIDTH-1 -> sum/cout/done valid after edge WIDTH. done therefore asserts WIDTH cycles after start is accepted. Throughput is one result per WIDTH+1 cycles (back-to-back via DONE).
- start in RUN: ignored; operands are not re-captured and there is no queueing.
- sum/cout: change only on entry to DONE; held indefinitely in IDLE and across new RUN operations.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} == a+b+cin exactly.
- Counter width: $clog2(WIDTH); it never exceeds WIDTH-1.
- rst asserted mid-RUN: operation aborted, all outputs return to reset values next edge, no done pulse.
- rst and start high together: rst wins.

Optional Feature:
Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Extra port sub (input, 1), captured with operands on an accepted start.
  - sub=1 computes a + ~b + 1: b is inverted at capture and the carry flop is forced to 1; cin is ignored.
  - In this mode cout=1 means no borrow (a>=b).
  - sub=0 behaves exactly as the base adder.
- Not defined:
  - sub port absent; add-only behaviour as above.
  - No extra logic or state.

Test Plan:
- WIDTH=8, reset then a=0x00, b=0x00, cin=0, start -> busy high 8 cycles; done pulses 8 cycles after accepted start; sum=0x00, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
- start pulsed mid-RUN with different operands -> ignored; result matches original operands; done asserts once. start held high through DONE -> second operation begins, second done pulse after 8 more cycles.
- rst asserted after 4 RUN cycles of 0xFF+0xFF -> next edge busy=0, done=0, sum=0, cout=0; no done pulse. A fresh start afterwards yields a correct result.
- WIDTH=3: exhaustive 128 combinations of a, b, cin compared against a+b+cin -> zero mismatches; sum stays stable between done pulses.
- With SERIAL_ADDER_SUB_EN, WIDTH=8:
  - sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0.
  - sub=1, a=0x07, b=0x05, cin=0 -> sum=0x02, cout=1.
  - sub=0 runs reproduce the add results above.
